// File: rtl/lv_ow_adc_req_rsp.sv
// Responder for the LV ctrl FSM ADC-request handshake: launches an ow ADC-read frame,
// waits for the HV response and returns a one-cycle ack with ok/err status.
module lv_ow_adc_req_rsp #(
  parameter int unsigned ADC_DATA_W  = 10,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ow_comm_en,
  input  logic                  i_fsm_ow_ctrl_req_adc,
  output logic                  o_ow_ctrl_fsm_ack_adc,
  output logic                  o_ow_ctrl_fsm_ack_adc_status,
  output logic                  o_ow_tx_adc_req,
  input  logic                  i_ow_tx_ack,
  input  logic                  i_ow_rx_vld,
  input  logic                  i_ow_rx_crc_err,
  input  logic [ADC_DATA_W-1:0] i_ow_rx_data,
  output logic [ADC_DATA_W-1:0] o_adc_data,
  output logic                  o_adc_data_upd,
  output logic [ERR_CNT_W-1:0]  o_fail_cnt
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StTxReq, StWaitRsp, StAck} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  status_q, status_d;
  logic                  ack_q;
  logic                  tx_req_q;
  logic                  upd_q, upd_d;
  logic [ADC_DATA_W-1:0] adc_data_q, adc_data_d;
  logic [ERR_CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic                  enter_ack;
  logic                  tmo_hit;

  assign tmo_hit = (tmo_cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    status_d   = status_q;
    upd_d      = 1'b0;
    adc_data_d = adc_data_q;
    enter_ack  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_fsm_ow_ctrl_req_adc) begin
          tmo_cnt_d = '0;
          if (i_ow_comm_en) begin
            state_d = StTxReq;
          end else begin
            state_d   = StAck;
            status_d  = 1'b1;
            enter_ack = 1'b1;
          end
        end
      end
      StTxReq: begin
        if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + CntW'(1);
        if (!i_ow_comm_en || (!i_ow_tx_ack && tmo_hit)) begin
          state_d   = StAck;
          status_d  = 1'b1;
          enter_ack = 1'b1;
        end else if (i_ow_tx_ack) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (!tmo_hit) tmo_cnt_d = tmo_cnt_q + CntW'(1);
        // Abort beats a response, and a response on the timeout cycle still counts.
        if (!i_ow_comm_en) begin
          state_d   = StAck;
          status_d  = 1'b1;
          enter_ack = 1'b1;
        end else if (i_ow_rx_vld) begin
          state_d   = StAck;
          status_d  = i_ow_rx_crc_err;
          enter_ack = 1'b1;
          if (!i_ow_rx_crc_err) begin
            adc_data_d = i_ow_rx_data;
            upd_d      = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d   = StAck;
          status_d  = 1'b1;
          enter_ack = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (enter_ack && status_d && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tmo_cnt_q  <= '0;
      status_q   <= 1'b0;
      ack_q      <= 1'b0;
      tx_req_q   <= 1'b0;
      upd_q      <= 1'b0;
      adc_data_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      status_q   <= status_d;
      ack_q      <= enter_ack;
      tx_req_q   <= (state_d == StTxReq);
      upd_q      <= upd_d;
      adc_data_q <= adc_data_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign o_ow_ctrl_fsm_ack_adc        = ack_q;
  assign o_ow_ctrl_fsm_ack_adc_status = status_q;
  assign o_ow_tx_adc_req              = tx_req_q;
  assign o_adc_data                   = adc_data_q;
  assign o_adc_data_upd               = upd_q;
  assign o_fail_cnt                   = fail_cnt_q;

endmodule
